// File: rtl/query_patch_pkg.sv
// Shared defaults and FSM state type for the query patch writer.
package query_patch_pkg;

   localparam int DATA_WIDTH_DEF = 11;
   localparam int PATCH_SIZE_DEF = 5;
   localparam int ADDR_WIDTH_DEF = 9;
   localparam int DEPTH_DEF      = 512;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/query_patch_writer.sv
// Packs PATCH_SIZE streamed elements into one wide word and writes a frame of
// DEPTH such patches to consecutive addresses of a single-port memory.
module query_patch_writer
   import query_patch_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int PATCH_SIZE = PATCH_SIZE_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [DATA_WIDTH-1:0]            in_data,
   output logic                             csb0,
   output logic                             web0,
   output logic [ADDR_WIDTH-1:0]            addr0,
   output logic [DATA_WIDTH*PATCH_SIZE-1:0] wpatch0,
   output logic                             busy,
   output logic                             done,
   output logic [ADDR_WIDTH:0]              patch_count,
   output state_t                           dbg_state_o
);

   localparam int PW    = DATA_WIDTH * PATCH_SIZE;
   localparam int IDX_W = (PATCH_SIZE > 1) ? $clog2(PATCH_SIZE) : 1;
   localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(PATCH_SIZE - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   // Handshake: an element moves when in_valid and in_ready are both high at
   // a rising edge; in_ready is high only while filling a patch.

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [PW-1:0]           patch_q, patch_d;
   logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
   logic                    strobe_q, strobe_d;
   logic [ADDR_WIDTH-1:0]   addr0_q, addr0_d;
   logic [PW-1:0]           wpatch0_q, wpatch0_d;
   logic                    last_elem;

   assign last_elem = in_valid && (idx_q == LAST_IDX);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (start) state_d = S_FILL;
         S_FILL:         if (last_elem) state_d = S_WRITE;
         S_WRITE:        state_d = (addr_q == LAST_ADDR) ? S_DONE : S_FILL;
         default:        state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      in_ready    = (state_q == S_FILL);
      busy        = (state_q == S_FILL) || (state_q == S_WRITE);
      done        = (state_q == S_DONE);
      dbg_state_o = state_q;
   end

   // Datapath next values; the memory strobe is asserted from the last
   // accepted element so it lands exactly on the WRITE cycle.
   always_comb begin
      idx_d     = idx_q;
      addr_d    = addr_q;
      patch_d   = patch_q;
      cnt_d     = cnt_q;
      strobe_d  = 1'b0;
      addr0_d   = addr0_q;
      wpatch0_d = wpatch0_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               idx_d  = '0;
               addr_d = '0;
               cnt_d  = '0;
            end
         end
         S_FILL: begin
            if (in_valid) begin
               patch_d[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] = in_data;
               if (idx_q == LAST_IDX) begin
                  idx_d     = '0;
                  strobe_d  = 1'b1;
                  addr0_d   = addr_q;
                  wpatch0_d = patch_d;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         S_WRITE: begin
            cnt_d = cnt_q + (ADDR_WIDTH+1)'(1);
            if (addr_q != LAST_ADDR) addr_d = addr_q + ADDR_WIDTH'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q     <= '0;
         addr_q    <= '0;
         patch_q   <= '0;
         cnt_q     <= '0;
         strobe_q  <= 1'b0;
         addr0_q   <= '0;
         wpatch0_q <= '0;
      end else begin
         idx_q     <= idx_d;
         addr_q    <= addr_d;
         patch_q   <= patch_d;
         cnt_q     <= cnt_d;
         strobe_q  <= strobe_d;
         addr0_q   <= addr0_d;
         wpatch0_q <= wpatch0_d;
      end
   end

   assign csb0        = ~strobe_q;
   assign web0        = ~strobe_q;
   assign addr0       = addr0_q;
   assign wpatch0     = wpatch0_q;
   assign patch_count = cnt_q;

endmodule

// File: tb/tb_query_patch_writer.sv
// Randomized scoreboard bench for query_patch_writer: a transaction-level model
// predicts every memory write and the per-cycle control outputs.
module tb_query_patch_writer;
   import query_patch_pkg::*;

   localparam int DW    = 11;
   localparam int PS    = 5;
   localparam int AW    = 9;
   localparam int DEPTH = 512;
   localparam int PW    = DW * PS;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready, csb0, web0, busy, done;
   logic [AW-1:0] addr0;
   logic [PW-1:0] wpatch0;
   logic [AW:0]   patch_count;
   state_t        dbg_state;

   query_patch_writer #(.DATA_WIDTH(DW), .PATCH_SIZE(PS), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .csb0(csb0), .web0(web0), .addr0(addr0), .wpatch0(wpatch0),
      .busy(busy), .done(done), .patch_count(patch_count), .dbg_state_o(dbg_state)
   );

   // Clock / reset
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int n_writes = 0;

   // Scoreboard: {address, patch} of every write the model expects.
   logic [AW+PW-1:0] exp_q[$];

   // Model of the frame in terms of patches and element counts.
   bit          m_active = 0;
   bit          m_write  = 0;
   bit          m_done   = 0;
   int          m_written = 0;
   int          m_elems   = 0;
   logic [PW-1:0] m_patch = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_write = 0; m_done = 0;
      m_written = 0; m_elems = 0; m_patch = '0;
   endtask

   // One clock of stimulus; control outputs are checked against the model
   // before the edge, then the model advances with the same inputs.
   task automatic step(input logic s, input logic v, input logic [DW-1:0] d, input logic r);
      logic [PW-1:0] elem;
      @(negedge clk);
      start = s; in_valid = v; in_data = d; rst = r;
      #1;
      chk("in_ready",    {63'd0, in_ready}, {63'd0, m_active && !m_write});
      chk("busy",        {63'd0, busy},     {63'd0, m_active});
      chk("done",        {63'd0, done},     {63'd0, m_done});
      chk("csb0",        {63'd0, csb0},     {63'd0, !m_write});
      chk("web0",        {63'd0, web0},     {63'd0, !m_write});
      chk("patch_count", 64'(patch_count),  64'(m_written));
      @(posedge clk);
      if (r) begin
         model_reset();
      end else if (m_write) begin
         m_write = 0;
         m_written++;
         if (m_written == DEPTH) begin
            m_active = 0;
            m_done   = 1;
         end
      end else if (m_active) begin
         if (v) begin
            elem    = PW'(d);
            m_patch = m_patch + (elem << (m_elems * DW));
            m_elems++;
            if (m_elems == PS) begin
               exp_q.push_back({AW'(m_written), m_patch});
               m_write = 1;
               m_elems = 0;
               m_patch = '0;
            end
         end
      end else if (s) begin
         m_active = 1; m_done = 0; m_written = 0; m_elems = 0; m_patch = '0;
      end
   endtask

   task automatic chk_reset_outputs();
      @(negedge clk);
      #1;
      chk("rst_addr0",   64'(addr0),   64'd0);
      chk("rst_wpatch0", 64'(wpatch0), 64'd0);
      chk("rst_csb0",    {63'd0, csb0}, 64'd1);
      chk("rst_web0",    {63'd0, web0}, 64'd1);
      chk("rst_ready",   {63'd0, in_ready}, 64'd0);
      chk("rst_busy",    {63'd0, busy}, 64'd0);
      chk("rst_done",    {63'd0, done}, 64'd0);
      chk("rst_count",   64'(patch_count), 64'd0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic send(input logic [DW-1:0] d);
      step(1'b0, 1'b1, d, 1'b0);
   endtask

   // Monitor: every memory strobe is popped and compared with the scoreboard.
   always @(negedge clk) begin
      logic [AW+PW-1:0] e;
      if (!rst && (csb0 === 1'b0 || web0 === 1'b0)) begin
         n_writes++;
         chk("strobe_pair", {63'd0, web0}, {63'd0, csb0});
         if (exp_q.size() == 0) begin
            chk("unexpected_write_addr", 64'(addr0), 64'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("write_addr",  64'(addr0),   64'(e[AW+PW-1:PW]));
            chk("write_patch", 64'(wpatch0), 64'(e[PW-1:0]));
         end
      end
   end

   initial begin
      int cyc;
      int writes_before;
      step(1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b1);
      chk_reset_outputs();

      // Single patch 1..5
      step(1'b1, 1'b0, '0, 1'b0);
      for (int k = 1; k <= 5; k++) send(DW'(k));
      idle(3);

      // in_valid high in IDLE and during WRITE is ignored
      step(1'b0, 1'b0, '0, 1'b1);
      chk_reset_outputs();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, DW'(99), 1'b0);
      step(1'b1, 1'b1, DW'(55), 1'b0);
      for (int k = 1; k <= 5; k++) send(DW'(10 * k));
      send(DW'(77));
      for (int k = 1; k <= 5; k++) send(DW'($urandom_range(0, (1 << DW) - 1)));
      idle(2);

      // Reset after 3 elements of patch 7 aborts without writing
      step(1'b0, 1'b0, '0, 1'b1);
      step(1'b1, 1'b0, '0, 1'b0);
      for (int i = 0; i < 7 * (PS + 1) + 3; i++) begin
         if (m_write) step(1'b0, 1'b0, '0, 1'b0);
         else         send(DW'($urandom_range(0, (1 << DW) - 1)));
      end
      writes_before = n_writes;
      step(1'b0, 1'b0, '0, 1'b1);
      chk_reset_outputs();
      idle(3);
      chk("no_write_after_abort", 64'(n_writes), 64'(writes_before));
      step(1'b1, 1'b0, '0, 1'b0);
      for (int k = 0; k < PS; k++) send(DW'($urandom_range(0, (1 << DW) - 1)));
      idle(3);

      // Full frame with gaps every 3rd cycle and stray starts mid-frame
      step(1'b0, 1'b0, '0, 1'b1);
      step(1'b1, 1'b0, '0, 1'b0);
      writes_before = n_writes;
      cyc = 0;
      while (!m_done && cyc < 20000) begin
         step(($urandom_range(0, 15) == 0), (cyc % 3 != 2),
              DW'($urandom_range(0, (1 << DW) - 1)), 1'b0);
         cyc++;
      end
      idle(2);
      chk("frame_writes", 64'(n_writes - writes_before), 64'(DEPTH));
      chk("frame_done",   {63'd0, done}, 64'd1);
      chk("frame_count",  64'(patch_count), 64'(DEPTH));
      chk("frame_last_addr", 64'(addr0), 64'(DEPTH - 1));
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, DW'(5), 1'b0);

      // Start from DONE begins a fresh frame at address 0
      step(1'b1, 1'b0, '0, 1'b0);
      idle(1);
      chk("restart_done",  {63'd0, done}, 64'd0);
      chk("restart_count", 64'(patch_count), 64'd0);
      for (int k = 0; k < 2 * PS; k++) begin
         if (m_write) idle(1);
         send(DW'($urandom_range(0, (1 << DW) - 1)));
      end
      idle(4);

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
